// File: rtl/hex_scan_display_if.sv
// Bus between user logic and the hex_scan_display multiplexed seven-segment driver.
// The master loads digit contents; the slave drives the board select and segment pins.
interface hex_scan_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lzb_en;
  logic                    load;
  logic [NUM_DIGITS-1:0]   seg_cs_pin;
  logic [7:0]              seg_data_0_pin;
  logic                    frame_tick;

  modport master (
    output data_in, dp_in, digit_en, lzb_en, load,
    input  seg_cs_pin, seg_data_0_pin, frame_tick
  );

  modport slave (
    input  data_in, dp_in, digit_en, lzb_en, load,
    output seg_cs_pin, seg_data_0_pin, frame_tick
  );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex driver for up to 8 seven-segment digits with per-slot blanking,
// leading-zero suppression and a shadow/display register pair swapped only at frame ends.
module hex_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  hex_scan_display_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_data, disp_data;
  logic [NUM_DIGITS-1:0]   sh_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   sh_en, disp_en;
  logic [NUM_DIGITS-1:0]   cs_q, cs_next, cur_sel;
  logic [7:0]              seg_q, seg_next;
  logic                    tick_q;

  logic       slot_end, frame_end, in_blank, dark;
  logic [3:0] cur_nib;
  logic       cur_dp, cur_en, cur_lz, quiet;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_blank  = (cnt < BLANK_END);

  // Walk from the top digit down: quiet stays high while every digit so far
  // is either disabled or a plain zero without its decimal point.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    cur_sel = '0;
    quiet   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      quiet = quiet & (~disp_en[k] | ((disp_data[4*k +: 4] == 4'h0) & ~disp_dp[k]));
      if (idx == IW'(k)) begin
        cur_nib    = disp_data[4*k +: 4];
        cur_dp     = disp_dp[k];
        cur_en     = disp_en[k];
        cur_lz     = quiet & (k != 0);
        cur_sel[k] = 1'b1;
      end
    end
  end

  assign dark = ~cur_en | (bus.lzb_en & cur_lz);

  always_comb begin
    cs_next  = '0;
    seg_next = '0;
    if (!in_blank && !dark) begin
      cs_next  = cur_sel;
      seg_next = {cur_dp, hex7(cur_nib)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      disp_en   <= '0;
      cs_q      <= '0;
      seg_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (bus.load) begin
        sh_data <= bus.data_in;
        sh_dp   <= bus.dp_in;
        sh_en   <= bus.digit_en;
      end
      // A load landing on the boundary edge bypasses the shadow so it is not a frame late.
      if (frame_end) begin
        disp_data <= bus.load ? bus.data_in  : sh_data;
        disp_dp   <= bus.load ? bus.dp_in    : sh_dp;
        disp_en   <= bus.load ? bus.digit_en : sh_en;
      end
      tick_q <= frame_end;
      cs_q   <= cs_next;
      seg_q  <= seg_next;
    end
  end

  assign bus.seg_cs_pin     = cs_q;
  assign bus.seg_data_0_pin = seg_q;
  assign bus.frame_tick     = tick_q;
endmodule
